// File: rtl/win3x3_gen.sv
// 3x3 neighbourhood window generator: two IMG_W-deep row delay lines, 3x3 shift
// registers and border replication, one registered window per raster pixel.
module win3x3_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sof,
    input  logic [DATA_WIDTH-1:0]     in_data,
    output logic                      out_valid,
    output logic                      out_sof,
    output logic                      out_eof,
    output logic [9*DATA_WIDTH-1:0]   out_win,
    output logic                      busy
);

    localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CNTW = $clog2(IMG_W + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    localparam logic [CW-1:0]   COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]   ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CNTW-1:0] CNT_END  = CNTW'(IMG_W);
    localparam logic [CW-1:0]   COL_ZERO = {CW{1'b0}};
    localparam logic [RW-1:0]   ROW_ZERO = {RW{1'b0}};

    logic [1:0]            state_r, state_nxt_s;
    logic [CW-1:0]         col_r, cen_col_r, ptr_s;
    logic [RW-1:0]         row_r, cen_row_r;
    logic [CNTW-1:0]       cnt_r;
    logic                  in_ready_r, busy_r, out_valid_r, out_sof_r, out_eof_r;
    logic [9*DATA_WIDTH-1:0] out_win_r, win_flat_s;
    logic                  accept_s, sof_s, step_s, emit_s;
    logic                  top_s, bot_s, left_s, right_s;
    logic [DATA_WIDTH-1:0] pix_s;
    logic [DATA_WIDTH-1:0] lb1_r [IMG_W];
    logic [DATA_WIDTH-1:0] lb2_r [IMG_W];
    logic [DATA_WIDTH-1:0] sr_r  [3][3];
    logic [DATA_WIDTH-1:0] sh_s  [3][3];
    logic [DATA_WIDTH-1:0] rw_s  [3][3];

    assign accept_s = in_valid & in_ready_r;
    assign sof_s    = accept_s & in_sof;
    assign step_s   = (accept_s & ((state_r != ST_IDLE) | in_sof)) | (state_r == ST_FLUSH);
    assign emit_s   = step_s & ~sof_s & ((state_r == ST_RUN) | (state_r == ST_FLUSH));
    assign pix_s    = (state_r == ST_FLUSH) ? {DATA_WIDTH{1'b0}} : in_data;
    assign ptr_s    = sof_s ? COL_ZERO : col_r;
    assign top_s    = (cen_row_r == ROW_ZERO);
    assign bot_s    = (cen_row_r == ROW_LAST);
    assign left_s   = (cen_col_r == COL_ZERO);
    assign right_s  = (cen_col_r == COL_LAST);

    // Frame sequencing: an accepted in_sof always restarts the frame in FILL
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sof_s) state_nxt_s = ST_FILL;
                else       state_nxt_s = ST_IDLE;
            end
            ST_FILL: begin
                if (sof_s)                          state_nxt_s = ST_FILL;
                else if (step_s && cnt_r == CNT_END) state_nxt_s = ST_RUN;
                else                                state_nxt_s = ST_FILL;
            end
            ST_RUN: begin
                if (sof_s)                                               state_nxt_s = ST_FILL;
                else if (step_s && row_r == ROW_LAST && col_r == COL_LAST) state_nxt_s = ST_FLUSH;
                else                                                     state_nxt_s = ST_RUN;
            end
            ST_FLUSH: begin
                if (cnt_r == CNT_END) state_nxt_s = ST_IDLE;
                else                  state_nxt_s = ST_FLUSH;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Input position, fill/flush tick count and centre coordinate of the next window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_r     <= COL_ZERO;
            row_r     <= ROW_ZERO;
            cnt_r     <= {CNTW{1'b0}};
            cen_col_r <= COL_ZERO;
            cen_row_r <= ROW_ZERO;
        end else if (step_s) begin
            if (sof_s) begin
                col_r     <= CW'(1);
                row_r     <= ROW_ZERO;
                cnt_r     <= CNTW'(1);
                cen_col_r <= COL_ZERO;
                cen_row_r <= ROW_ZERO;
            end else begin
                if (col_r == COL_LAST) begin
                    col_r <= COL_ZERO;
                    row_r <= (state_r == ST_FLUSH) ? row_r : row_r + RW'(1);
                end else begin
                    col_r <= col_r + CW'(1);
                    row_r <= row_r;
                end
                if (state_r == ST_FILL || state_r == ST_FLUSH) begin
                    cnt_r <= (cnt_r == CNT_END) ? {CNTW{1'b0}} : cnt_r + CNTW'(1);
                end else begin
                    cnt_r <= cnt_r;
                end
                if (emit_s) begin
                    if (cen_col_r == COL_LAST) begin
                        cen_col_r <= COL_ZERO;
                        cen_row_r <= bot_s ? ROW_ZERO : cen_row_r + RW'(1);
                    end else begin
                        cen_col_r <= cen_col_r + CW'(1);
                        cen_row_r <= cen_row_r;
                    end
                end else begin
                    cen_col_r <= cen_col_r;
                    cen_row_r <= cen_row_r;
                end
            end
        end else begin
            col_r     <= col_r;
            row_r     <= row_r;
            cnt_r     <= cnt_r;
            cen_col_r <= cen_col_r;
            cen_row_r <= cen_row_r;
        end
    end

    // Row delay lines and window shift registers; contents are never exposed before being overwritten
    always_ff @(posedge clk) begin
        if (step_s) begin
            lb1_r[ptr_s] <= pix_s;
            lb2_r[ptr_s] <= lb1_r[ptr_s];
            for (int i = 0; i < 3; i++) begin
                sr_r[i][0] <= sr_r[i][1];
                sr_r[i][1] <= sr_r[i][2];
            end
            sr_r[0][2] <= lb2_r[ptr_s];
            sr_r[1][2] <= lb1_r[ptr_s];
            sr_r[2][2] <= pix_s;
        end else begin
            sr_r <= sr_r;
        end
    end

    // Post-shift window with border rows, then border columns, replaced by the centre line
    always_comb begin
        win_flat_s = {9*DATA_WIDTH{1'b0}};
        for (int i = 0; i < 3; i++) begin
            sh_s[i][0] = sr_r[i][1];
            sh_s[i][1] = sr_r[i][2];
        end
        sh_s[0][2] = lb2_r[ptr_s];
        sh_s[1][2] = lb1_r[ptr_s];
        sh_s[2][2] = pix_s;
        for (int j = 0; j < 3; j++) begin
            rw_s[0][j] = top_s ? sh_s[1][j] : sh_s[0][j];
            rw_s[1][j] = sh_s[1][j];
            rw_s[2][j] = bot_s ? sh_s[1][j] : sh_s[2][j];
        end
        for (int i = 0; i < 3; i++) begin
            win_flat_s[DATA_WIDTH*(3*i)   +: DATA_WIDTH] = left_s  ? rw_s[i][1] : rw_s[i][0];
            win_flat_s[DATA_WIDTH*(3*i+1) +: DATA_WIDTH] = rw_s[i][1];
            win_flat_s[DATA_WIDTH*(3*i+2) +: DATA_WIDTH] = right_s ? rw_s[i][1] : rw_s[i][2];
        end
    end

    // Registered state and outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_sof_r   <= 1'b0;
            out_eof_r   <= 1'b0;
            out_win_r   <= {9*DATA_WIDTH{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s != ST_FLUSH);
            busy_r      <= (state_nxt_s != ST_IDLE);
            out_valid_r <= emit_s;
            out_sof_r   <= emit_s & top_s & left_s;
            out_eof_r   <= emit_s & bot_s & right_s;
            if (emit_s) out_win_r <= win_flat_s;
            else        out_win_r <= out_win_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign out_sof   = out_sof_r;
    assign out_eof   = out_eof_r;
    assign out_win   = out_win_r;

endmodule

// File: tb/tb_win3x3_gen.sv
// Randomized bench for win3x3_gen on a 4x3 frame: clamp-based reference windows,
// per-window latency from recorded step cycles, abort, back-to-back and reset-in-flush.
module tb_win3x3_gen;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready, in_sof;
    logic [DW-1:0]   in_data;
    logic            out_valid, out_sof, out_eof, busy;
    logic [9*DW-1:0] out_win;

    win3x3_gen #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sof(in_sof), .in_data(in_data), .out_valid(out_valid),
        .out_sof(out_sof), .out_eof(out_eof), .out_win(out_win), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9*DW-1:0] win;
        logic            sof;
        logic            eof;
        int              need;
    } exp_t;

    exp_t            exp_q[$];
    int              stepcyc[int];
    int              gstep = 0;
    int              cyc = 0;
    int              n_tests = 0;
    int              n_fail = 0;
    int              n_valid = 0;
    logic [DW-1:0]   img [H][W];
    logic [9*DW-1:0] first_win, last_win;
    int              wa [9];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    function automatic logic [9*DW-1:0] ref_win(input int r, input int c);
        logic [9*DW-1:0] w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[DW*(3*i+j) +: DW] = img[clampi(r+i-1, H-1)][clampi(c+j-1, W-1)];
        return w;
    endfunction

    function automatic logic [9*DW-1:0] pack9(input int v [9]);
        logic [9*DW-1:0] w = '0;
        for (int k = 0; k < 9; k++) w[DW*k +: DW] = DW'(v[k]);
        return w;
    endfunction

    task automatic rand_img();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = DW'($urandom);
    endtask

    // Drives n pixels of img (n < W*H means the frame is cut short by the next in_sof)
    task automatic send_frame(input int n, input int gap, input bit count_ready);
        int base = gstep;
        int idx = 0;
        int last = 0;
        int tries = 0;
        int lowcnt = 0;
        for (int k = 0; k < W*H; k++) begin
            if (n == W*H || k < n - W - 1) begin
                exp_t e;
                e.win  = ref_win(k / W, k % W);
                e.sof  = (k == 0);
                e.eof  = (k == W*H - 1);
                e.need = base + k + W + 1;
                exp_q.push_back(e);
            end
        end
        while (idx < n && tries < 1000) begin
            tries++;
            if (gap > 0 && $urandom_range(99) < gap) begin
                in_valid = 1'b0;
                in_sof   = 1'($urandom_range(1));
                in_data  = DW'($urandom);
            end else begin
                in_valid = 1'b1;
                in_sof   = (idx == 0);
                in_data  = img[idx / W][idx % W];
                if (in_ready) begin
                    stepcyc[gstep] = cyc + 1;
                    last = cyc + 1;
                    gstep++;
                    idx++;
                end
            end
            @(negedge clk);
        end
        if (idx < n) check("accept_timeout", 72'(idx), 72'(n));
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (n == W*H) begin
            for (int t = 0; t <= W; t++) begin
                stepcyc[gstep] = last + 1 + t;
                gstep++;
            end
            if (count_ready) begin
                while (!in_ready && lowcnt < 50) begin
                    lowcnt++;
                    @(negedge clk);
                end
                check("ready_low_cycles", 72'(lowcnt), 72'(W + 1));
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            t++;
            @(negedge clk);
        end
        check("drain", 72'(exp_q.size()), 72'(0));
        repeat (3) @(negedge clk);
    endtask

    // Scoreboard: every window must match the reference and appear the cycle after its step
    always @(negedge clk) begin
        if (out_valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check("extra_window", 72'(1), 72'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("win", out_win, e.win);
                check("sof", 72'(out_sof), 72'(e.sof));
                check("eof", 72'(out_eof), 72'(e.eof));
                check("latency", 72'(cyc), stepcyc.exists(e.need) ? 72'(stepcyc[e.need]) : 72'(0));
                if (out_sof) first_win = out_win;
                if (out_eof) last_win = out_win;
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 72'(in_ready), 72'(1));
        check("rst_out_valid", 72'(out_valid), 72'(0));
        check("rst_busy", 72'(busy), 72'(0));
        check("rst_out_win", out_win, 72'(0));
        check("rst_sof_eof", 72'({out_sof, out_eof}), 72'(0));
        rst = 1'b0;
        @(negedge clk);

        // pixels without in_sof while idle are dropped
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_sof = 1'b0; in_data = DW'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("drop_busy", 72'(busy), 72'(0));

        // directed ramp 10*r+c, gapless
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = DW'(10*r + c);
        n_valid = 0;
        send_frame(W*H, 0, 1'b1);
        drain();
        check("pulses_gapless", 72'(n_valid), 72'(W*H));
        check("busy_after", 72'(busy), 72'(0));
        wa = '{0, 0, 1, 0, 0, 1, 10, 10, 11};
        check("first_window", first_win, pack9(wa));
        wa = '{12, 13, 13, 22, 23, 23, 22, 23, 23};
        check("last_window", last_win, pack9(wa));

        // same frame with ~30% idle cycles
        n_valid = 0;
        send_frame(W*H, 30, 1'b1);
        drain();
        check("pulses_gaps", 72'(n_valid), 72'(W*H));

        // abort at (1,2) by a new in_sof, then the full replacement frame
        rand_img();
        n_valid = 0;
        send_frame(W + 2, 0, 1'b0);
        rand_img();
        send_frame(W*H, 0, 1'b1);
        drain();
        check("pulses_abort", 72'(n_valid), 72'(1 + W*H));

        // back-to-back random frames with gaps
        for (int f = 0; f < 4; f++) begin
            rand_img();
            send_frame(W*H, (f == 1) ? 0 : 25, 1'b1);
        end
        drain();

        // reset pulsed during FLUSH
        rand_img();
        send_frame(W*H, 0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstf_out_valid", 72'(out_valid), 72'(0));
        check("rstf_out_win", out_win, 72'(0));
        check("rstf_in_ready", 72'(in_ready), 72'(1));
        check("rstf_busy", 72'(busy), 72'(0));
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rand_img();
        n_valid = 0;
        send_frame(W*H, 20, 1'b1);
        drain();
        check("pulses_after_rst", 72'(n_valid), 72'(W*H));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/win3x3_gen.md
Name: win3x3_gen

Overview:
Consumer end of the line-buffer datapath. Accepts a raster pixel stream, holds the two previous rows in internal IMG_W-deep delay lines, and emits one 3x3 neighbourhood window per pixel with edge replication at the frame borders. After the last input pixel of a frame it self-flushes the final row. It feeds the 3x3 filter stages (min filter, guided filter) of the dehaze pipeline.

Parameters:
DATA_WIDTH, 8, pixel width in bits
IMG_W, 640, active pixels per row (>=3)
IMG_H, 480, active rows per frame (>=3)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  input pixel present
in_ready  out  1  block can accept a pixel; accept = in_valid & in_ready
in_sof  in  1  qualifies the accepted pixel as row 0, col 0 of a frame
in_data  in  DATA_WIDTH  input pixel
out_valid  out  1  out_win valid this cycle, single-cycle pulse per window
out_sof  out  1  with out_valid: window centred on (0,0)
out_eof  out  1  with out_valid: window centred on (IMG_H-1, IMG_W-1)
out_win  out  9*DATA_WIDTH  window; slice [DATA_WIDTH*(3*i+j) +: DATA_WIDTH] = row i (0=top), col j (0=left); centre at i=j=1
busy  out  1  high in FILL, RUN or FLUSH

Behaviour:
- Reset (async assert, sync release): state IDLE; in_ready=1, out_valid=0, out_sof=0, out_eof=0, out_win=0, busy=0; row/col/step counters zero. Delay-line contents are don't-care (never exposed before overwritten).
- Step: one accepted input pixel, or one internal flush tick in FLUSH. Delay lines, 3x3 shift registers and counters advance only on a step; with no step all state holds (input gaps allowed, any length).
- States: IDLE -> FILL on accepted pixel with in_sof=1 (accepted pixels with in_sof=0 in IDLE are dropped). FILL -> RUN once step count reaches IMG_W+1. RUN -> FLUSH after accepting linear index IMG_W*IMG_H-1. FLUSH: in_ready=0; exactly IMG_W+1 ticks, one per cycle; then -> IDLE.
- Window for centre (r,c) is produced on the step with step index r*IMG_W+c+IMG_W+1 (accept of input pixel (r+1,c+1), or the matching flush tick). out_valid, out_win, out_sof, out_eof are registered: asserted on the cycle after that step, for exactly one cycle. Exactly IMG_W*IMG_H windows per frame, in raster order.
- Edge replication (muxed after shift registers): r=0 -> top row := centre row; r=IMG_H-1 -> bottom row := centre row; c=0 -> left column := centre column; c=IMG_W-1 -> right column := centre column. Corners apply both. Wrapped data from an adjacent row never appears in out_win.
- in_sof=1 on an accepted pixel in FILL/RUN: frame aborted without emitting remaining windows; counters restart, that pixel is (0,0), state FILL. in_sof while in FLUSH cannot occur (in_ready=0).
- Back-to-back frames: first pixel of next frame is accepted in the cycle after FLUSH exits to IDLE.
- Counters: column counter wraps IMG_W-1 -> 0 and increments row; widths $clog2 of their range; no arithmetic overflow beyond that.
- Reset mid-frame or mid-flush: immediate return to reset values; no further out_valid until a new in_sof frame.

Test Plan:
- IMG_W=4, IMG_H=3, pixel = 10*r+c, continuous in_valid with in_sof on first -> first out_valid the cycle after accepting pixel (1,1); out_sof=1; out_win rows = {0,0,1},{0,0,1},{10,10,11}.
- Same frame, end -> in_ready low exactly 5 cycles after last accept; last window out_eof=1, rows = {12,13,13},{22,23,23},{22,23,23}; exactly 12 out_valid pulses, then busy=0.
- Same frame with random in_valid gaps (30% idle) -> identical 12-window sequence to gapless run; no out_valid on non-step cycles.
- Interior check, 640x480 ramp pixel = (r+c) mod 256 -> window at (100,200) equals the 9 neighbours exactly; total 307200 windows.
- in_sof reasserted at (1,2) of 4x3 frame -> windows of aborted frame stop; new frame yields full 12-window sequence starting with out_sof.
- rst pulsed during FLUSH -> outputs zero asynchronously, in_ready=1, busy=0; next frame produces correct first window.
